// File: rtl/rle_video_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : rle_video_decoder_if
//  Description : Head-word stream between the word fetcher (master) and the
//                RLE video decoder (slave). The fetcher presents a head word
//                with data_ready; the decoder pulses shift_data to pop it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rle_video_decoder_if #(
  parameter int DATA_W = 20
);
  logic [DATA_W-1:0] data_in;
  logic              data_ready;
  logic              shift_data;

  modport master (
    output data_in,
    output data_ready,
    input  shift_data
  );

  modport slave (
    input  data_in,
    input  data_ready,
    output shift_data
  );
endinterface
`default_nettype wire

// File: rtl/rle_video_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rle_video_decoder
//  Description : Expands RLE pixel runs into one colour per visible pixel
//                clock, loads audio samples during horizontal blanking,
//                drives a PWM audio bit and flags pixel underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_video_decoder #(
  parameter int                   COLOUR_W  = 9,
  parameter int                   RUN_W     = 10,
  parameter int                   PWM_W     = 8,
  parameter int                   DATA_W    = 20,
  parameter logic [COLOUR_W-1:0]  UNDER_COL = 9'h1C0
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  rle_video_decoder_if.slave       stream,
  input  wire logic                horizontal_blank,
  input  wire logic                vertical_blank,
  output logic [COLOUR_W-1:0]      colour,
  output logic [PWM_W-1:0]         pwm_sample,
  output logic                     pwm_out,
  output logic                     enable_vga,
  output logic                     underflow
);

  localparam logic [RUN_W-1:0] c_run_one = RUN_W'(1);
  localparam logic [PWM_W-1:0] c_pwm_one = PWM_W'(1);

  // Word layout and sample width must fit; refuse to elaborate otherwise.
  if (DATA_W != 1 + RUN_W + COLOUR_W) begin : g_bad_data_w
    $error("rle_video_decoder: DATA_W must equal 1+RUN_W+COLOUR_W");
  end
  if (PWM_W > COLOUR_W + RUN_W) begin : g_bad_pwm_w
    $error("rle_video_decoder: PWM_W must not exceed COLOUR_W+RUN_W");
  end

  // Run state
  logic [COLOUR_W-1:0] r_cur_colour;
  logic [RUN_W-1:0]    r_run_left;
  logic                r_cur_valid;
  // Output and audio state
  logic [COLOUR_W-1:0] r_colour;
  logic [PWM_W-1:0]    r_pwm_sample;
  logic [PWM_W-1:0]    r_pwm_cnt;
  logic                r_pwm_out;
  logic                r_enable_vga;
  logic                r_underflow;
  logic                r_audio_taken;

  // Head-word decode
  logic                w_visible;
  logic                w_head_audio;
  logic [RUN_W-1:0]    w_head_run;
  logic [COLOUR_W-1:0] w_head_colour;
  logic [PWM_W-1:0]    w_head_sample;
  logic                w_needs_run;
  logic                w_pop_audio;
  logic                w_pop_pixel;

  assign w_visible     = !horizontal_blank && !vertical_blank;
  assign w_head_audio  = stream.data_in[DATA_W-1];
  assign w_head_run    = stream.data_in[COLOUR_W +: RUN_W];
  assign w_head_colour = stream.data_in[COLOUR_W-1:0];
  assign w_head_sample = stream.data_in[PWM_W-1:0];

  // A new run is wanted when idle, or when the last pixel of the current run
  // goes out this cycle so the next run follows without a bubble.
  assign w_needs_run = !r_cur_valid || (w_visible && (r_run_left == '0));

  // At most one pop per cycle: audio and pixel heads are mutually exclusive.
  // An audio head outside its hblank window blocks the stream until then.
  assign w_pop_audio = rst_n && stream.data_ready && w_head_audio &&
                       horizontal_blank && !r_audio_taken;
  assign w_pop_pixel = rst_n && stream.data_ready && !w_head_audio && w_needs_run;

  assign stream.shift_data = w_pop_audio || w_pop_pixel;

  // Run register: load on pixel pop, otherwise consume one pixel per visible clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_colour <= '0;
      r_run_left   <= '0;
      r_cur_valid  <= 1'b0;
    end else if (w_pop_pixel) begin
      r_cur_colour <= w_head_colour;
      r_run_left   <= w_head_run;
      r_cur_valid  <= 1'b1;
    end else if (w_visible && r_cur_valid) begin
      if (r_run_left != '0) begin
        r_run_left <= r_run_left - c_run_one;
      end else begin
        r_cur_valid <= 1'b0;
      end
    end
  end

  // Pixel output: run colour when available, underflow colour otherwise, black in blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_colour <= '0;
    end else if (w_visible) begin
      r_colour <= r_cur_valid ? r_cur_colour : UNDER_COL;
    end else begin
      r_colour <= '0;
    end
  end

  // Sticky status: underflow on a starved visible pixel, enable on first run load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow  <= 1'b0;
      r_enable_vga <= 1'b0;
    end else begin
      if (w_visible && !r_cur_valid) begin
        r_underflow <= 1'b1;
      end
      if (w_pop_pixel) begin
        r_enable_vga <= 1'b1;
      end
    end
  end

  // Audio load: one sample per hblank interval, re-armed whenever hblank drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_sample  <= '0;
      r_audio_taken <= 1'b0;
    end else begin
      if (w_pop_audio) begin
        r_pwm_sample <= w_head_sample;
      end
      if (!horizontal_blank) begin
        r_audio_taken <= 1'b0;
      end else if (w_pop_audio) begin
        r_audio_taken <= 1'b1;
      end
    end
  end

  // PWM: free-running counter compared against the held sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + c_pwm_one;
      r_pwm_out <= (r_pwm_cnt < r_pwm_sample);
    end
  end

  assign colour     = r_colour;
  assign pwm_sample = r_pwm_sample;
  assign pwm_out    = r_pwm_out;
  assign enable_vga = r_enable_vga;
  assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rle_video_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rle_video_decoder
//  Description : Randomised scoreboard bench for rle_video_decoder against a
//                pixel-count reference model of the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_video_decoder;

  localparam int COLOUR_W = 9;
  localparam int RUN_W    = 10;
  localparam int PWM_W    = 8;
  localparam int DATA_W   = 20;
  localparam logic [8:0] c_under = 9'h1C0;
  localparam int c_h_total = 32;
  localparam int c_h_vis   = 24;
  localparam int c_v_total = 12;
  localparam int c_v_vis   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hb, vb;
  logic [8:0] colour;
  logic [7:0] pwm_sample;
  logic       pwm_out, enable_vga, underflow;

  rle_video_decoder_if #(.DATA_W(DATA_W)) stream ();

  rle_video_decoder #(
    .COLOUR_W (COLOUR_W),
    .RUN_W    (RUN_W),
    .PWM_W    (PWM_W),
    .DATA_W   (DATA_W),
    .UNDER_COL(c_under)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stream          (stream),
    .horizontal_blank(hb),
    .vertical_blank  (vb),
    .colour          (colour),
    .pwm_sample      (pwm_sample),
    .pwm_out         (pwm_out),
    .enable_vga      (enable_vga),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] colour;
    logic       shift;
    logic [7:0] sample;
    logic       pwm;
    logic       en;
    logic       und;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] up_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model: a run is held as a count of pixels still to show.
  int          m_pix_left;
  logic [8:0]  m_run_col, m_colour;
  logic [7:0]  m_sample;
  int          m_cnt;
  logic        m_pwm, m_en, m_und, m_taken;

  logic        in_hb, in_vb, in_dr;
  logic [19:0] in_word;
  logic        p_audio, p_pixel;
  int          hpos, line;
  bit          refill;

  function automatic logic [19:0] pix(int l, logic [8:0] c);
    return {1'b0, 10'(l), c};
  endfunction

  function automatic logic [19:0] aud(logic [7:0] s);
    return {1'b1, 11'h0, s};
  endfunction

  function automatic logic [19:0] rand_word();
    if ($urandom_range(5) == 0) return aud(8'($urandom_range(255)));
    return pix(int'($urandom_range(7)), 9'($urandom_range(511)));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic init_model();
    m_pix_left = 0;
    m_run_col  = '0;
    m_colour   = '0;
    m_sample   = '0;
    m_cnt      = 0;
    m_pwm      = 1'b0;
    m_en       = 1'b0;
    m_und      = 1'b0;
    m_taken    = 1'b0;
  endtask

  // Present the next cycle's timing and head word, and predict the pop.
  task automatic drive_inputs();
    bit vis;
    in_hb = (hpos >= c_h_vis);
    in_vb = (line >= c_v_vis);
    if (refill && up_q.size() == 0) up_q.push_back(rand_word());
    if (up_q.size() > 0) begin
      in_word = up_q[0];
      in_dr   = refill ? ($urandom_range(99) < 90) : 1'b1;
    end else begin
      in_word = 20'($urandom);
      in_dr   = 1'b0;
    end
    vis     = !in_hb && !in_vb;
    p_audio = in_dr && in_word[19] && in_hb && !m_taken;
    p_pixel = in_dr && !in_word[19] && (m_pix_left == 0 || (vis && m_pix_left == 1));
    stream.data_in    = in_word;
    stream.data_ready = in_dr;
    hb = in_hb;
    vb = in_vb;
    hpos = (hpos + 1) % c_h_total;
    if (hpos == 0) line = (line + 1) % c_v_total;
  endtask

  // Advance the model across one active edge using the inputs just applied.
  task automatic model_update();
    bit vis;
    vis = !in_hb && !in_vb;
    if (vis) begin
      if (m_pix_left > 0) begin
        m_colour = m_run_col;
        m_pix_left--;
      end else begin
        m_colour = c_under;
        m_und    = 1'b1;
      end
    end else begin
      m_colour = '0;
    end
    if (p_pixel) begin
      m_run_col  = in_word[8:0];
      m_pix_left = int'(in_word[18:9]) + 1;
      m_en       = 1'b1;
    end
    m_pwm = (m_cnt < int'(m_sample));
    m_cnt = (m_cnt + 1) % 256;
    if (p_audio) m_sample = in_word[7:0];
    if (!in_hb) m_taken = 1'b0;
    else if (p_audio) m_taken = 1'b1;
    if (p_audio || p_pixel) void'(up_q.pop_front());
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    model_update();
    drive_inputs();
    e.colour = m_colour;
    e.shift  = p_audio || p_pixel;
    e.sample = m_sample;
    e.pwm    = m_pwm;
    e.en     = m_en;
    e.und    = m_und;
    sb.push_back(e);
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_shift"},     32'(stream.shift_data), 32'd0);
    chk({tag, "_colour"},    32'(colour),            32'd0);
    chk({tag, "_sample"},    32'(pwm_sample),        32'd0);
    chk({tag, "_pwm"},       32'(pwm_out),           32'd0);
    chk({tag, "_enable"},    32'(enable_vga),        32'd0);
    chk({tag, "_underflow"}, 32'(underflow),         32'd0);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin : mon
      exp_t e;
      e = sb.pop_front();
      chk("colour",     32'(colour),            32'(e.colour));
      chk("shift_data", 32'(stream.shift_data), 32'(e.shift));
      chk("pwm_sample", 32'(pwm_sample),        32'(e.sample));
      chk("pwm_out",    32'(pwm_out),           32'(e.pwm));
      chk("enable_vga", 32'(enable_vga),        32'(e.en));
      chk("underflow",  32'(underflow),         32'(e.und));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    init_model();
    hpos   = 26;
    line   = 0;
    refill = 1'b0;
    up_q   = {pix(2, 9'h1FF), pix(0, 9'h0AA), pix(1, 9'h055),
              aud(8'h80), aud(8'h40), pix(4, 9'h123), pix(30, 9'h0F0)};
    drive_inputs();
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed word list first, then starvation once it runs dry.
    for (int i = 0; i < 200; i++) step();
    refill = 1'b1;
    for (int i = 0; i < 1500; i++) step();

    // Asynchronous reset between edges, in the middle of traffic.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    init_model();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 800; i++) step();
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
